sfm_tcdm_adapter: RTL and testbench

SFM_TCDM_ADAPTER -- requirements
Module: sfm_tcdm_adapter

---
 rtl/sfm_tcdm_adapter.sv | 258 +++++++++++++++++++++++++
 tb/tb_sfm_tcdm_adapter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfm_tcdm_adapter.sv
// ---------------------------------------------------------------------------
// sfm_tcdm_adapter
//
// Splits one wide (MP x 32-bit) memory request into MP independent 32-bit
// TCDM requests and reassembles the narrow read responses into one wide
// response.
//
// Each narrow port keeps its request and payload until it is granted.
// Ports may be granted in any order and on any cycle. Read data from each
// port lands in a small per-port FIFO. A wide response is offered once every
// FIFO holds a word. Read credits bound the number of outstanding wide reads,
// so the FIFOs can never overflow.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   wide_req_i/gnt_o     wide request handshake
//   wide_add_i           byte base address of the wide access
//   wide_wen_i           1 = read, 0 = write
//   wide_be_i/data_i     wide byte enables / write data (port 0 at LSB)
//   wide_r_data_o        reassembled read data (port 0 at LSB)
//   wide_r_valid_o       read response valid
//   wide_r_ready_i       read response backpressure
//   tcdm_*               MP narrow TCDM ports (req/gnt/add/wen/be/data/r_*)
//   busy_o               issuing or reads still outstanding
//   err_o                sticky: a narrow response arrived unexpectedly
// ---------------------------------------------------------------------------
module sfm_tcdm_adapter #(
  parameter  int unsigned MP     = 4,
  parameter  int unsigned DEPTH  = 2,
  parameter  int unsigned STRIDE = 4,
  localparam int unsigned DW     = MP * 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // wide request side
  input  logic                 wide_req_i,
  output logic                 wide_gnt_o,
  input  logic [31:0]          wide_add_i,
  input  logic                 wide_wen_i,
  input  logic [DW/8-1:0]      wide_be_i,
  input  logic [DW-1:0]        wide_data_i,
  // wide response side
  output logic [DW-1:0]        wide_r_data_o,
  output logic                 wide_r_valid_o,
  input  logic                 wide_r_ready_i,
  // narrow TCDM ports
  output logic [MP-1:0]        tcdm_req_o,
  input  logic [MP-1:0]        tcdm_gnt_i,
  output logic [MP-1:0][31:0]  tcdm_add_o,
  output logic [MP-1:0]        tcdm_wen_o,
  output logic [MP-1:0][3:0]   tcdm_be_o,
  output logic [MP-1:0][31:0]  tcdm_data_o,
  input  logic [MP-1:0][31:0]  tcdm_r_data_i,
  input  logic [MP-1:0]        tcdm_r_valid_i,
  // status
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                      state_q, state_d;
  logic [MP-1:0]               pending_q, pending_d;
  logic [31:0]                 add_q, add_d;
  logic                        wen_q, wen_d;
  logic [DW/8-1:0]             be_q, be_d;
  logic [DW-1:0]               data_q, data_d;
  logic [CW-1:0]               rd_cnt_q, rd_cnt_d;
  logic [MP-1:0][CW-1:0]       exp_q, exp_d;
  logic [MP-1:0][DEPTH-1:0][31:0] mem_q, mem_d;
  logic [MP-1:0][PW-1:0]       rptr_q, rptr_d, wptr_q, wptr_d;
  logic [MP-1:0][CW-1:0]       cnt_q, cnt_d;
  logic                        err_q, err_d;

  logic                        credit, all_done, any_new, pop;
  logic [MP-1:0]               new_pending, rd_grant, push, stray, fifo_nonempty;

  // Accept conditions for the wide side. In ISSUE a new request may only be
  // taken once every remaining pending port is granted in this very cycle.
  always_comb begin : wide_accept
    new_pending = '0;
    for (int i = 0; i < int'(MP); i++) begin
      new_pending[i] = wide_wen_i | (|wide_be_i[i*4 +: 4]);
    end
    any_new  = |new_pending;
    credit   = !wide_wen_i || (rd_cnt_q < DEPTH_C);
    all_done = &(~pending_q | tcdm_gnt_i);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin : fsm_state
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stay in ISSUE only while an accepted access still has
  // narrow traffic to send.
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wide_gnt_o && any_new) state_d = ISSUE;
      end
      ISSUE: begin
        if (all_done) state_d = (wide_gnt_o && any_new) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, held low while reset is asserted.
  always_comb begin : fsm_outputs
    wide_gnt_o = 1'b0;
    busy_o     = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE:    wide_gnt_o = wide_req_i && credit;
        ISSUE:   wide_gnt_o = wide_req_i && credit && all_done;
        default: wide_gnt_o = 1'b0;
      endcase
      busy_o = (state_q == ISSUE) || (rd_cnt_q != '0);
    end
  end

  // Narrow ports are driven purely from the registered access.
  always_comb begin : narrow_drive
    tcdm_req_o  = '0;
    tcdm_wen_o  = '0;
    tcdm_add_o  = '0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    for (int i = 0; i < int'(MP); i++) begin
      tcdm_req_o[i]  = pending_q[i] & rst_ni;
      tcdm_wen_o[i]  = wen_q;
      tcdm_add_o[i]  = add_q + 32'(i * STRIDE);
      tcdm_be_o[i]   = be_q[i*4 +: 4];
      tcdm_data_o[i] = data_q[i*32 +: 32];
    end
  end

  // Response side: FIFO heads form the wide word; all FIFOs pop together.
  always_comb begin : response_status
    fifo_nonempty = '0;
    wide_r_data_o = '0;
    for (int i = 0; i < int'(MP); i++) begin
      fifo_nonempty[i]          = (cnt_q[i] != '0);
      wide_r_data_o[i*32 +: 32] = mem_q[i][rptr_q[i]];
    end
    wide_r_valid_o = rst_ni & (&fifo_nonempty);
    pop            = wide_r_valid_o & wide_r_ready_i;
  end

  // Datapath next values: access capture, pending mask, read credits,
  // per-port expected-response counters and response FIFOs.
  always_comb begin : datapath_next
    add_d     = add_q;
    wen_d     = wen_q;
    be_d      = be_q;
    data_d    = data_q;
    pending_d = pending_q & ~tcdm_gnt_i;
    rd_cnt_d  = rd_cnt_q;
    exp_d     = exp_q;
    mem_d     = mem_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    rd_grant  = '0;
    push      = '0;
    stray     = '0;

    if (wide_gnt_o) begin
      add_d     = wide_add_i;
      wen_d     = wide_wen_i;
      be_d      = wide_be_i;
      data_d    = wide_data_i;
      pending_d = new_pending;
    end

    case ({wide_gnt_o && wide_wen_i, pop})
      2'b10:   rd_cnt_d = rd_cnt_q + CNT_ONE;
      2'b01:   rd_cnt_d = rd_cnt_q - CNT_ONE;
      default: rd_cnt_d = rd_cnt_q;
    endcase

    for (int i = 0; i < int'(MP); i++) begin
      rd_grant[i] = tcdm_req_o[i] & tcdm_gnt_i[i] & wen_q;
      // A response in the same cycle as its grant is still expected.
      push[i]     = tcdm_r_valid_i[i] & ((exp_q[i] != '0) | rd_grant[i]);
      stray[i]    = tcdm_r_valid_i[i] & ~push[i];

      case ({rd_grant[i], push[i]})
        2'b10:   exp_d[i] = exp_q[i] + CNT_ONE;
        2'b01:   exp_d[i] = exp_q[i] - CNT_ONE;
        default: exp_d[i] = exp_q[i];
      endcase

      if (push[i]) begin
        mem_d[i][wptr_q[i]] = tcdm_r_data_i[i];
        wptr_d[i] = (wptr_q[i] == PTR_LAST) ? '0 : wptr_q[i] + PTR_ONE;
      end
      if (pop) begin
        rptr_d[i] = (rptr_q[i] == PTR_LAST) ? '0 : rptr_q[i] + PTR_ONE;
      end

      case ({push[i], pop})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end

    err_d = err_q | (|stray);
  end

  // Control registers with reset.
  always_ff @(posedge clk_i) begin : control_regs
    if (!rst_ni) begin
      pending_q <= '0;
      rd_cnt_q  <= '0;
      exp_q     <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rd_cnt_q  <= rd_cnt_d;
      exp_q     <= exp_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Payload and FIFO storage need no reset; validity lives in the counters.
  always_ff @(posedge clk_i) begin : payload_regs
    add_q  <= add_d;
    wen_q  <= wen_d;
    be_q   <= be_d;
    data_q <= data_d;
    mem_q  <= mem_d;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_sfm_tcdm_adapter.sv
// ---------------------------------------------------------------------------
// tb_sfm_tcdm_adapter
//
// Exercises the adapter with MP=4, DEPTH=2, STRIDE=4. Each scenario task
// drives the wide side and plays the TCDM memory itself. Expected wide read
// data is queued when a read is issued and compared when the response is
// popped. Inputs change 1 time unit after the rising edge. Outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sfm_tcdm_adapter;

  localparam int MP     = 4;
  localparam int DEPTH  = 2;
  localparam int STRIDE = 4;
  localparam int DW     = MP * 32;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                wide_req_i;
  logic                wide_gnt_o;
  logic [31:0]         wide_add_i;
  logic                wide_wen_i;
  logic [DW/8-1:0]     wide_be_i;
  logic [DW-1:0]       wide_data_i;
  logic [DW-1:0]       wide_r_data_o;
  logic                wide_r_valid_o;
  logic                wide_r_ready_i;
  logic [MP-1:0]       tcdm_req_o;
  logic [MP-1:0]       tcdm_gnt_i;
  logic [MP-1:0][31:0] tcdm_add_o;
  logic [MP-1:0]       tcdm_wen_o;
  logic [MP-1:0][3:0]  tcdm_be_o;
  logic [MP-1:0][31:0] tcdm_data_o;
  logic [MP-1:0][31:0] tcdm_r_data_i;
  logic [MP-1:0]       tcdm_r_valid_i;
  logic                busy_o;
  logic                err_o;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb_q[$];

  always #5 clk_i = ~clk_i;

  sfm_tcdm_adapter #(.MP(MP), .DEPTH(DEPTH), .STRIDE(STRIDE)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wide_req_i     (wide_req_i),
    .wide_gnt_o     (wide_gnt_o),
    .wide_add_i     (wide_add_i),
    .wide_wen_i     (wide_wen_i),
    .wide_be_i      (wide_be_i),
    .wide_data_i    (wide_data_i),
    .wide_r_data_o  (wide_r_data_o),
    .wide_r_valid_o (wide_r_valid_o),
    .wide_r_ready_i (wide_r_ready_i),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .tcdm_r_data_i  (tcdm_r_data_i),
    .tcdm_r_valid_i (tcdm_r_valid_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample_point();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    wide_req_i     = 1'b0;
    wide_add_i     = '0;
    wide_wen_i     = 1'b0;
    wide_be_i      = '0;
    wide_data_i    = '0;
    wide_r_ready_i = 1'b0;
    tcdm_gnt_i     = '0;
    tcdm_r_data_i  = '0;
    tcdm_r_valid_i = '0;
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    next_cycle();
    rst_ni = 1'b1;
  endtask

  // Reset holds every handshake output low even with a request present.
  task automatic test_reset();
    idle_inputs();
    rst_ni     = 1'b0;
    wide_req_i = 1'b1;
    wide_wen_i = 1'b1;
    wide_be_i  = '1;
    next_cycle();
    next_cycle();
    sample_point();
    checks++; if (wide_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0", wide_gnt_o); end
    checks++; if (wide_r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0", wide_r_valid_o); end
    checks++; if (tcdm_req_o !== 4'h0) begin errors++; $display("[TB] FAIL reset_req: got %h expected 0", tcdm_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
    next_cycle();
    rst_ni = 1'b1;
    idle_inputs();
    next_cycle();
  endtask

  // Single read: all grants in cycle 1, responses in cycle 2, wide valid in 3.
  task automatic test_read();
    logic [31:0]   ea [4] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
    logic [DW-1:0] rdat   = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
    logic [DW-1:0] expd;
    wide_req_i = 1'b1;
    wide_wen_i = 1'b1;
    wide_add_i = 32'h0000_1000;
    wide_be_i  = '1;
    sb_q.push_back(rdat);
    sample_point();
    checks++; if (wide_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL read_gnt: got %b expected 1", wide_gnt_o); end
    next_cycle();
    wide_req_i = 1'b0;
    tcdm_gnt_i = '1;
    sample_point();
    checks++; if (tcdm_req_o !== 4'hF) begin errors++; $display("[TB] FAIL read_req: got %h expected f", tcdm_req_o); end
    checks++; if (tcdm_wen_o !== 4'hF) begin errors++; $display("[TB] FAIL read_wen: got %h expected f", tcdm_wen_o); end
    for (int i = 0; i < MP; i++) begin
      checks++; if (tcdm_add_o[i] !== ea[i]) begin errors++; $display("[TB] FAIL read_add%0d: got %h expected %h", i, tcdm_add_o[i], ea[i]); end
    end
    next_cycle();
    tcdm_gnt_i     = '0;
    tcdm_r_valid_i = '1;
    tcdm_r_data_i  = rdat;
    sample_point();
    checks++; if (tcdm_req_o !== 4'h0) begin errors++; $display("[TB] FAIL read_req_done: got %h expected 0", tcdm_req_o); end
    checks++; if (wide_r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL read_rvalid_early: got %b expected 0", wide_r_valid_o); end
    next_cycle();
    tcdm_r_valid_i = '0;
    wide_r_ready_i = 1'b1;
    sample_point();
    checks++; if (wide_r_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL read_rvalid: got %b expected 1", wide_r_valid_o); end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("[TB] FAIL read_data: response with empty scoreboard"); end
    else begin
      expd = sb_q.pop_front();
      if (wide_r_data_o !== expd) begin errors++; $display("[TB] FAIL read_data: got %h expected %h", wide_r_data_o, expd); end
    end
    next_cycle();
    wide_r_ready_i = 1'b0;
    sample_point();
    checks++; if (wide_r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL read_rvalid_after: got %b expected 0", wide_r_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL read_busy_after: got %b expected 0", busy_o); end
    next_cycle();
    idle_inputs();
  endtask

  // Sparse writes with grants tied high, then a zero-enable write.
  task automatic test_write();
    wide_req_i  = 1'b1;
    wide_wen_i  = 1'b0;
    wide_add_i  = 32'h0000_2000;
    wide_be_i   = 16'h00F0;
    wide_data_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    tcdm_gnt_i  = '1;
    sample_point();
    checks++; if (wide_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_gnt: got %b expected 1", wide_gnt_o); end
    next_cycle();
    wide_add_i  = 32'h0000_3000;
    wide_be_i   = 16'h000F;
    wide_data_i = {32'h0, 32'h0, 32'h0, 32'h5555_5555};
    sample_point();
    checks++; if (tcdm_req_o !== 4'b0010) begin errors++; $display("[TB] FAIL wr_req: got %b expected 0010", tcdm_req_o); end
    checks++; if (tcdm_add_o[1] !== 32'h0000_2004) begin errors++; $display("[TB] FAIL wr_add1: got %h expected 00002004", tcdm_add_o[1]); end
    checks++; if (tcdm_data_o[1] !== 32'h2222_2222) begin errors++; $display("[TB] FAIL wr_data1: got %h expected 22222222", tcdm_data_o[1]); end
    checks++; if (tcdm_be_o[1] !== 4'hF) begin errors++; $display("[TB] FAIL wr_be1: got %h expected f", tcdm_be_o[1]); end
    checks++; if (tcdm_wen_o[1] !== 1'b0) begin errors++; $display("[TB] FAIL wr_wen1: got %b expected 0", tcdm_wen_o[1]); end
    checks++; if (wide_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_b2b_gnt: got %b expected 1", wide_gnt_o); end
    next_cycle();
    wide_add_i = 32'h0000_3800;
    wide_be_i  = '0;
    sample_point();
    checks++; if (tcdm_req_o !== 4'b0001) begin errors++; $display("[TB] FAIL wr2_req: got %b expected 0001", tcdm_req_o); end
    checks++; if (tcdm_add_o[0] !== 32'h0000_3000) begin errors++; $display("[TB] FAIL wr2_add0: got %h expected 00003000", tcdm_add_o[0]); end
    checks++; if (tcdm_data_o[0] !== 32'h5555_5555) begin errors++; $display("[TB] FAIL wr2_data0: got %h expected 55555555", tcdm_data_o[0]); end
    checks++; if (wide_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_zero_gnt: got %b expected 1", wide_gnt_o); end
    next_cycle();
    wide_req_i = 1'b0;
    sample_point();
    checks++; if (tcdm_req_o !== 4'h0) begin errors++; $display("[TB] FAIL wr_zero_req: got %h expected 0", tcdm_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL wr_busy: got %b expected 0", busy_o); end
    next_cycle();
    idle_inputs();
  endtask

  // Port 3 granted five cycles after the others; the next request waits.
  task automatic test_staggered();
    wide_req_i  = 1'b1;
    wide_wen_i  = 1'b0;
    wide_add_i  = 32'h0000_4000;
    wide_be_i   = '1;
    wide_data_i = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    sample_point();
    checks++; if (wide_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL stag_gnt: got %b expected 1", wide_gnt_o); end
    next_cycle();
    wide_add_i  = 32'h0000_5000;
    wide_be_i   = 16'h0001;
    wide_data_i = {32'h0, 32'h0, 32'h0, 32'hBEEF_0000};
    tcdm_gnt_i  = 4'b0111;
    sample_point();
    checks++; if (tcdm_req_o !== 4'hF) begin errors++; $display("[TB] FAIL stag_req_all: got %h expected f", tcdm_req_o); end
    checks++; if (wide_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL stag_gnt_hold0: got %b expected 0", wide_gnt_o); end
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      tcdm_gnt_i = (k == 4) ? 4'b1000 : 4'b0000;
      sample_point();
      checks++; if (tcdm_req_o !== 4'b1000) begin errors++; $display("[TB] FAIL stag_req_c%0d: got %b expected 1000", k, tcdm_req_o); end
      checks++; if (tcdm_add_o[3] !== 32'h0000_400C) begin errors++; $display("[TB] FAIL stag_add3_c%0d: got %h expected 0000400c", k, tcdm_add_o[3]); end
      checks++; if (tcdm_data_o[3] !== 32'hCAFE_0003) begin errors++; $display("[TB] FAIL stag_data3_c%0d: got %h expected cafe0003", k, tcdm_data_o[3]); end
      checks++; if (wide_gnt_o !== ((k == 4) ? 1'b1 : 1'b0)) begin errors++; $display("[TB] FAIL stag_gnt_c%0d: got %b expected %b", k, wide_gnt_o, (k == 4)); end
    end
    next_cycle();
    wide_req_i = 1'b0;
    tcdm_gnt_i = 4'b0001;
    sample_point();
    checks++; if (tcdm_req_o !== 4'b0001) begin errors++; $display("[TB] FAIL stag_next_req: got %b expected 0001", tcdm_req_o); end
    checks++; if (tcdm_add_o[0] !== 32'h0000_5000) begin errors++; $display("[TB] FAIL stag_next_add: got %h expected 00005000", tcdm_add_o[0]); end
    next_cycle();
    tcdm_gnt_i = '0;
    sample_point();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL stag_busy: got %b expected 0", busy_o); end
    next_cycle();
    idle_inputs();
  endtask

  // Credit limit of two reads under backpressure, with a write slipping in.
  task automatic test_credit();
    logic [DW-1:0] da = {32'hA003_0003, 32'hA002_0002, 32'hA001_0001, 32'hA000_0000};
    logic [DW-1:0] db = {32'hB003_0013, 32'hB002_0012, 32'hB001_0011, 32'hB000_0010};
    logic [DW-1:0] dc = {32'hC003_0023, 32'hC002_0022, 32'hC001_0021, 32'hC000_0020};
    logic [DW-1:0] expd;
    wide_r_ready_i = 1'b0;
    tcdm_gnt_i     = '1;
    wide_req_i     = 1'b1;
    wide_wen_i     = 1'b1;
    wide_be_i      = '1;
    wide_add_i     = 32'h0000_0100;
    sb_q.push_back(da);
    sample_point();
    checks++; if (wide_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL cr_gnt_a: got %b expected 1", wide_gnt_o); end
    next_cycle();
    wide_add_i = 32'h0000_0200;
    sb_q.push_back(db);
    sample_point();
    checks++; if (wide_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL cr_gnt_b: got %b expected 1", wide_gnt_o); end
    next_cycle();
    wide_add_i     = 32'h0000_0300;
    tcdm_r_valid_i = '1;
    tcdm_r_data_i  = da;
    sample_point();
    checks++; if (wide_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL cr_gnt_c_block: got %b expected 0", wide_gnt_o); end
    next_cycle();
    tcdm_r_data_i = db;
    sample_point();
    checks++; if (wide_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL cr_gnt_c_block2: got %b expected 0", wide_gnt_o); end
    checks++; if (wide_r_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL cr_rvalid_a: got %b expected 1", wide_r_valid_o); end
    checks++; if (wide_r_data_o !== sb_q[0]) begin errors++; $display("[TB] FAIL cr_head_a: got %h expected %h", wide_r_data_o, sb_q[0]); end
    next_cycle();
    tcdm_r_valid_i = '0;
    wide_wen_i     = 1'b0;
    wide_be_i      = 16'h000F;
    wide_add_i     = 32'h0000_0700;
    sample_point();
    checks++; if (wide_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL cr_write_gnt: got %b expected 1", wide_gnt_o); end
    checks++; if (wide_r_data_o !== sb_q[0]) begin errors++; $display("[TB] FAIL cr_head_stable: got %h expected %h", wide_r_data_o, sb_q[0]); end
    next_cycle();
    wide_wen_i = 1'b1;
    wide_be_i  = '1;
    wide_add_i = 32'h0000_0300;
    sample_point();
    checks++; if (tcdm_req_o !== 4'b0001) begin errors++; $display("[TB] FAIL cr_write_req: got %b expected 0001", tcdm_req_o); end
    checks++; if (tcdm_wen_o[0] !== 1'b0) begin errors++; $display("[TB] FAIL cr_write_wen: got %b expected 0", tcdm_wen_o[0]); end
    checks++; if (wide_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL cr_gnt_c_block3: got %b expected 0", wide_gnt_o); end
    next_cycle();
    wide_r_ready_i = 1'b1;
    sample_point();
    checks++; if (wide_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL cr_gnt_c_block4: got %b expected 0", wide_gnt_o); end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("[TB] FAIL cr_data_a: response with empty scoreboard"); end
    else begin
      expd = sb_q.pop_front();
      if (wide_r_valid_o !== 1'b1 || wide_r_data_o !== expd) begin errors++; $display("[TB] FAIL cr_data_a: got v=%b %h expected v=1 %h", wide_r_valid_o, wide_r_data_o, expd); end
    end
    next_cycle();
    wide_r_ready_i = 1'b0;
    sb_q.push_back(dc);
    sample_point();
    checks++; if (wide_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL cr_gnt_c: got %b expected 1", wide_gnt_o); end
    next_cycle();
    wide_req_i = 1'b0;
    sample_point();
    checks++; if (tcdm_req_o !== 4'hF) begin errors++; $display("[TB] FAIL cr_req_c: got %h expected f", tcdm_req_o); end
    next_cycle();
    tcdm_r_valid_i = '1;
    tcdm_r_data_i  = dc;
    next_cycle();
    tcdm_r_valid_i = '0;
    wide_r_ready_i = 1'b1;
    for (int r = 0; r < 2; r++) begin
      sample_point();
      checks++;
      if (sb_q.size() == 0) begin errors++; $display("[TB] FAIL cr_data_%0d: response with empty scoreboard", r); end
      else begin
        expd = sb_q.pop_front();
        if (wide_r_valid_o !== 1'b1 || wide_r_data_o !== expd) begin errors++; $display("[TB] FAIL cr_data_%0d: got v=%b %h expected v=1 %h", r, wide_r_valid_o, wide_r_data_o, expd); end
      end
      next_cycle();
    end
    wide_r_ready_i = 1'b0;
    sample_point();
    checks++; if (wide_r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL cr_rvalid_end: got %b expected 0", wide_r_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL cr_busy_end: got %b expected 0", busy_o); end
    next_cycle();
    idle_inputs();
  endtask

  // Stray narrow response: dropped, sticky error until reset.
  task automatic test_unexpected();
    logic [DW-1:0] dd = {32'hD000_0033, 32'hD000_0022, 32'hD000_0011, 32'hD000_0000};
    logic [DW-1:0] expd;
    tcdm_r_valid_i = 4'b0100;
    tcdm_r_data_i  = {32'h0, 32'hDEAD_DEAD, 32'h0, 32'h0};
    next_cycle();
    tcdm_r_valid_i = '0;
    sample_point();
    checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL unexp_err: got %b expected 1", err_o); end
    checks++; if (wide_r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL unexp_rvalid: got %b expected 0", wide_r_valid_o); end
    next_cycle();
    wide_req_i = 1'b1;
    wide_wen_i = 1'b1;
    wide_be_i  = '1;
    wide_add_i = 32'h0000_8000;
    sb_q.push_back(dd);
    next_cycle();
    wide_req_i = 1'b0;
    tcdm_gnt_i = '1;
    next_cycle();
    tcdm_gnt_i     = '0;
    tcdm_r_valid_i = '1;
    tcdm_r_data_i  = dd;
    next_cycle();
    tcdm_r_valid_i = '0;
    wide_r_ready_i = 1'b1;
    sample_point();
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("[TB] FAIL unexp_data: response with empty scoreboard"); end
    else begin
      expd = sb_q.pop_front();
      if (wide_r_valid_o !== 1'b1 || wide_r_data_o !== expd) begin errors++; $display("[TB] FAIL unexp_data: got v=%b %h expected v=1 %h", wide_r_valid_o, wide_r_data_o, expd); end
    end
    next_cycle();
    wide_r_ready_i = 1'b0;
    sample_point();
    checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL unexp_err_sticky: got %b expected 1", err_o); end
    next_cycle();
    pulse_reset();
    sample_point();
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL unexp_err_clear: got %b expected 0", err_o); end
    next_cycle();
    idle_inputs();
  endtask

  // Reset while port 1 is still pending; late responses become errors.
  task automatic test_reset_mid();
    wide_req_i = 1'b1;
    wide_wen_i = 1'b1;
    wide_be_i  = '1;
    wide_add_i = 32'h0000_6000;
    next_cycle();
    wide_req_i = 1'b0;
    tcdm_gnt_i = 4'b1101;
    next_cycle();
    tcdm_gnt_i = '0;
    sample_point();
    checks++; if (tcdm_req_o !== 4'b0010) begin errors++; $display("[TB] FAIL rmid_pending: got %b expected 0010", tcdm_req_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL rmid_busy: got %b expected 1", busy_o); end
    next_cycle();
    rst_ni = 1'b0;
    sample_point();
    checks++; if (tcdm_req_o !== 4'h0) begin errors++; $display("[TB] FAIL rmid_req_in_reset: got %h expected 0", tcdm_req_o); end
    next_cycle();
    rst_ni = 1'b1;
    sample_point();
    checks++; if (tcdm_req_o !== 4'h0) begin errors++; $display("[TB] FAIL rmid_req_after: got %h expected 0", tcdm_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy_after: got %b expected 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_err_before: got %b expected 0", err_o); end
    next_cycle();
    tcdm_r_valid_i = 4'b1101;
    tcdm_r_data_i  = '1;
    next_cycle();
    tcdm_r_valid_i = '0;
    sample_point();
    checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL rmid_late_err: got %b expected 1", err_o); end
    checks++; if (wide_r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_rvalid: got %b expected 0", wide_r_valid_o); end
    next_cycle();
    pulse_reset();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_staggered();
    test_credit();
    test_unexpected();
    test_reset_mid();
    checks++; if (sb_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
